// File: rtl/c_block_writer.sv
// -----------------------------------------------------------------------------
// c_block_writer
// Drains one C result block (N rows x cur_block_m INT32 words) from the on-chip
// output buffer and writes it to DDR through an AXI4 write master. The block is
// cut into INCR bursts of at most MAX_BURST beats that never cross a 4 KB page.
// Only one burst is outstanding: the next AW waits for the previous B.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   st_req              start pulse (ignored unless idle)
//   N, M, BLOCK_M       rows, total C columns, nominal block width
//   j_block             block column offset in elements
//   base_c_addr         C matrix byte base
//   stride_c_row_bytes  DDR row pitch in bytes
//   st_busy/st_done     busy level / one-cycle completion pulse
//   st_err              sticky: any non-OKAY BRESP during this operation
//   c_rd_en/addr/data   output-buffer read port (data one cycle after enable)
//   M_AXI_AW*/W*/B*     AXI4 write address / data / response channels
// -----------------------------------------------------------------------------
module c_block_writer #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int C_ADDR_W       = 14,
  parameter int MAX_BURST      = 16,
  parameter int AXI_USER_WIDTH = 1,
  parameter int AXI_ID_W       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st_req,
  input  logic [15:0]               N,
  input  logic [15:0]               M,
  input  logic [15:0]               BLOCK_M,
  input  logic [15:0]               j_block,
  input  logic [ADDR_W-1:0]         base_c_addr,
  input  logic [31:0]               stride_c_row_bytes,
  output logic                      st_busy,
  output logic                      st_done,
  output logic                      st_err,
  output logic                      c_rd_en,
  output logic [C_ADDR_W-1:0]       c_rd_addr,
  input  logic [DATA_W-1:0]         c_rd_data,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [ADDR_W-1:0]         M_AXI_AWADDR,
  output logic [AXI_ID_W-1:0]       M_AXI_AWID,
  output logic [7:0]                M_AXI_AWLEN,
  output logic [2:0]                M_AXI_AWSIZE,
  output logic [1:0]                M_AXI_AWBURST,
  output logic                      M_AXI_AWLOCK,
  output logic [3:0]                M_AXI_AWCACHE,
  output logic [2:0]                M_AXI_AWPROT,
  output logic [3:0]                M_AXI_AWQOS,
  output logic [AXI_USER_WIDTH-1:0] M_AXI_AWUSER,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  output logic [DATA_W-1:0]         M_AXI_WDATA,
  output logic [DATA_W/8-1:0]       M_AXI_WSTRB,
  output logic                      M_AXI_WLAST,
  output logic [AXI_USER_WIDTH-1:0] M_AXI_WUSER,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic [AXI_ID_W-1:0]       M_AXI_BID,
  input  logic [AXI_USER_WIDTH-1:0] M_AXI_BUSER
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_AW    = 3'd2,
    S_W     = 3'd3,
    S_B     = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

  state_t              state_r;
  logic [15:0]         n_r, cur_m_r, row_r, col_r, len_r;
  logic [15:0]         rd_left_r, w_left_r;
  logic [ADDR_W-1:0]   row_addr_r, awaddr_r;
  logic [31:0]         stride_r;
  logic [7:0]          awlen_r;
  logic                awvalid_r, bready_r, busy_r, done_r, err_r;
  logic                c_rd_en_r, rd_vld_r;
  logic [C_ADDR_W-1:0] c_rd_addr_r, rd_ptr_r;
  logic [DATA_W-1:0]   fifo_mem_r [2];
  logic                fifo_wp_r, fifo_rp_r;
  logic [1:0]          fifo_cnt_r;

  logic [15:0]         cur_m_s;
  logic [ADDR_W-1:0]   burst_addr_s;
  logic [31:0]         rem_s, to4k_s, len_a_s, len_s;
  logic                wvalid_s, pop_s, push_s, issue_s;
  logic [2:0]          claim_s;
  logic                unused_s;

  // Effective block width: columns left of M starting at j_block, capped at BLOCK_M.
  always_comb begin
    cur_m_s = 16'd0;
    if (M > j_block) begin
      if ((M - j_block) < BLOCK_M) begin
        cur_m_s = M - j_block;
      end else begin
        cur_m_s = BLOCK_M;
      end
    end else begin
      cur_m_s = 16'd0;
    end
  end

  // Burst length: min(remaining columns in row, MAX_BURST, words to next 4 KB page).
  assign burst_addr_s = row_addr_r + (ADDR_W'(col_r) << 2);
  assign rem_s        = 32'(cur_m_r) - 32'(col_r);
  assign to4k_s       = (32'd4096 - 32'(burst_addr_s[11:0])) >> 2;
  assign len_a_s      = (rem_s < MAX_BURST_W) ? rem_s : MAX_BURST_W;
  assign len_s        = (len_a_s < to4k_s) ? len_a_s : to4k_s;

  // A read is issued only if the slot it will land in is guaranteed free:
  // entries held + reads in flight, less the beat leaving this cycle, below 2.
  assign wvalid_s = (state_r == S_W) && (fifo_cnt_r != 2'd0);
  assign pop_s    = wvalid_s && M_AXI_WREADY;
  assign push_s   = rd_vld_r;
  assign claim_s  = {1'b0, fifo_cnt_r} + {2'b00, rd_vld_r} + {2'b00, c_rd_en_r} - {2'b00, pop_s};
  assign issue_s  = ((state_r == S_AW) || (state_r == S_W)) &&
                    (rd_left_r != 16'd0) && (claim_s < 3'd2);

  // Control FSM: operation latch, burst sequencing, buffer reads and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      n_r         <= 16'd0;
      cur_m_r     <= 16'd0;
      row_r       <= 16'd0;
      col_r       <= 16'd0;
      len_r       <= 16'd0;
      rd_left_r   <= 16'd0;
      w_left_r    <= 16'd0;
      row_addr_r  <= '0;
      awaddr_r    <= '0;
      stride_r    <= 32'd0;
      awlen_r     <= 8'd0;
      awvalid_r   <= 1'b0;
      bready_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      c_rd_en_r   <= 1'b0;
      c_rd_addr_r <= '0;
      rd_ptr_r    <= '0;
    end else begin
      done_r    <= 1'b0;
      c_rd_en_r <= issue_s;
      // Buffer words of a block are row-major, so the read pointer simply counts.
      if (issue_s) begin
        c_rd_addr_r <= rd_ptr_r;
        rd_ptr_r    <= rd_ptr_r + {{(C_ADDR_W-1){1'b0}}, 1'b1};
        rd_left_r   <= rd_left_r - 16'd1;
      end
      case (state_r)
        S_IDLE: begin
          if (st_req) begin
            n_r        <= N;
            cur_m_r    <= cur_m_s;
            stride_r   <= stride_c_row_bytes;
            row_addr_r <= base_c_addr + (ADDR_W'(j_block) << 2);
            row_r      <= 16'd0;
            col_r      <= 16'd0;
            rd_ptr_r   <= '0;
            busy_r     <= 1'b1;
            err_r      <= 1'b0;
            state_r    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if ((n_r == 16'd0) || (cur_m_r == 16'd0)) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_DONE;
          end else begin
            awaddr_r  <= burst_addr_s;
            awlen_r   <= 8'(len_s - 32'd1);
            len_r     <= 16'(len_s);
            rd_left_r <= 16'(len_s);
            w_left_r  <= 16'(len_s);
            awvalid_r <= 1'b1;
            state_r   <= S_AW;
          end
        end
        S_AW: begin
          if (M_AXI_AWREADY) begin
            awvalid_r <= 1'b0;
            state_r   <= S_W;
          end
        end
        S_W: begin
          if (pop_s) begin
            w_left_r <= w_left_r - 16'd1;
            if (w_left_r == 16'd1) begin
              bready_r <= 1'b1;
              state_r  <= S_B;
            end
          end
        end
        S_B: begin
          if (M_AXI_BVALID) begin
            bready_r <= 1'b0;
            if (M_AXI_BRESP != 2'b00) begin
              err_r <= 1'b1;
            end
            if ((col_r + len_r) == cur_m_r) begin
              col_r      <= 16'd0;
              row_r      <= row_r + 16'd1;
              row_addr_r <= row_addr_r + ADDR_W'(stride_r);
              if ((row_r + 16'd1) == n_r) begin
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
                state_r <= S_DONE;
              end else begin
                state_r <= S_SETUP;
              end
            end else begin
              col_r   <= col_r + len_r;
              state_r <= S_SETUP;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Two-entry W FIFO fed by buffer read data one cycle after each read enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_r      <= 1'b0;
      fifo_mem_r[0] <= '0;
      fifo_mem_r[1] <= '0;
      fifo_wp_r     <= 1'b0;
      fifo_rp_r     <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      rd_vld_r <= c_rd_en_r;
      if (push_s) begin
        fifo_mem_r[fifo_wp_r] <= c_rd_data;
        fifo_wp_r             <= ~fifo_wp_r;
      end
      if (pop_s) begin
        fifo_rp_r <= ~fifo_rp_r;
      end
      fifo_cnt_r <= fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  assign st_busy       = busy_r;
  assign st_done       = done_r;
  assign st_err        = err_r;
  assign c_rd_en       = c_rd_en_r;
  assign c_rd_addr     = c_rd_addr_r;
  assign M_AXI_AWVALID = awvalid_r;
  assign M_AXI_AWADDR  = awaddr_r;
  assign M_AXI_AWLEN   = awlen_r;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWSIZE  = 3'($clog2(DATA_W/8));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_WVALID  = wvalid_s;
  assign M_AXI_WDATA   = fifo_mem_r[fifo_rp_r];
  assign M_AXI_WSTRB   = {(DATA_W/8){1'b1}};
  assign M_AXI_WLAST   = wvalid_s && (w_left_r == 16'd1);
  assign M_AXI_WUSER   = '0;
  assign M_AXI_BREADY  = bready_r;

  assign unused_s = ^{M_AXI_BID, M_AXI_BUSER};

endmodule

// File: tb/tb_c_block_writer.sv
`timescale 1ns/1ps
module tb_c_block_writer;
  logic        clk = 1'b0;
  logic        rst, st_req;
  logic [15:0] N, M, BLOCK_M, j_block;
  logic [31:0] base_c_addr, stride_c_row_bytes;
  logic        st_busy, st_done, st_err, c_rd_en;
  logic [13:0] c_rd_addr;
  logic [31:0] c_rd_data;
  logic        AWVALID, AWREADY, AWID, AWLOCK, AWUSER;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE, AWPROT;
  logic [1:0]  AWBURST, BRESP;
  logic [3:0]  AWCACHE, AWQOS, WSTRB;
  logic        WVALID, WREADY, WLAST, WUSER, BVALID, BREADY, BID, BUSER;
  logic [31:0] WDATA;

  always #5 clk = ~clk;

  c_block_writer dut (
    .clk(clk), .rst(rst), .st_req(st_req), .N(N), .M(M), .BLOCK_M(BLOCK_M),
    .j_block(j_block), .base_c_addr(base_c_addr), .stride_c_row_bytes(stride_c_row_bytes),
    .st_busy(st_busy), .st_done(st_done), .st_err(st_err),
    .c_rd_en(c_rd_en), .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY), .M_AXI_AWADDR(AWADDR),
    .M_AXI_AWID(AWID), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE),
    .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS), .M_AXI_AWUSER(AWUSER),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_WDATA(WDATA),
    .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WUSER(WUSER),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_BRESP(BRESP),
    .M_AXI_BID(BID), .M_AXI_BUSER(BUSER)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] cbuf [0:16383];
  logic [31:0] ddr [logic [31:0]];
  logic [31:0] aw_addr_q [$];
  int          aw_len_q [$];
  int          wlast_q [$];
  int  first_aw_cyc, done_cyc, done_cnt, beats, stab_err, ord_err, wlast_err, busy_done_err;
  int  burst_no, err_burst, t0;
  bit  rand_mode = 1'b0;

  // AXI slave + DDR model + output-buffer model
  logic        aw_active, b_pend, b_hs, aw_stall, w_stall, w_prev_last, rd_en_smp, rst_smp;
  int          aw_beat, aw_cur_len, b_wait;
  logic [31:0] aw_cur_addr, aw_prev_addr, w_prev_data;
  logic [7:0]  aw_prev_len;
  logic [13:0] rd_addr_smp;

  initial begin : slave
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = 1'b0; BUSER = 1'b0;
    c_rd_data = 32'd0; aw_active = 1'b0; b_pend = 1'b0; aw_stall = 1'b0; w_stall = 1'b0;
    rd_en_smp = 1'b0; rd_addr_smp = 14'd0; aw_beat = 0; aw_cur_len = 0; b_wait = 0;
    aw_cur_addr = 32'd0; aw_prev_addr = 32'd0; aw_prev_len = 8'd0; w_prev_data = 32'd0;
    w_prev_last = 1'b0;
    forever begin
      @(negedge clk);
      b_hs = 1'b0;
      rst_smp = rst;
      if (rst) begin
        aw_active = 1'b0; b_pend = 1'b0; aw_stall = 1'b0; w_stall = 1'b0; rd_en_smp = 1'b0;
      end else begin
        if (AWVALID && first_aw_cyc < 0) first_aw_cyc = cyc;
        if (st_done) begin done_cnt++; done_cyc = cyc; if (st_busy) busy_done_err++; end
        if (aw_stall && !(AWVALID && AWADDR == aw_prev_addr && AWLEN == aw_prev_len)) stab_err++;
        if (w_stall && !(WVALID && WDATA == w_prev_data && WLAST == w_prev_last)) stab_err++;
        aw_stall = AWVALID && !AWREADY; aw_prev_addr = AWADDR; aw_prev_len = AWLEN;
        w_stall = WVALID && !WREADY; w_prev_data = WDATA; w_prev_last = WLAST;
        if (WVALID && WREADY) begin
          if (!aw_active) ord_err++;
          else begin
            ddr[aw_cur_addr + 32'(4 * aw_beat)] = WDATA;
            beats++;
            if (WLAST != (aw_beat == aw_cur_len)) wlast_err++;
            if (WLAST) wlast_q.push_back(beats);
            if (aw_beat == aw_cur_len) begin
              aw_active = 1'b0; b_pend = 1'b1;
              b_wait = rand_mode ? int'($urandom_range(0, 5)) : 0;
            end
            aw_beat++;
          end
        end
        if (AWVALID && AWREADY) begin
          if (aw_active || b_pend || BVALID) ord_err++;
          aw_addr_q.push_back(AWADDR); aw_len_q.push_back(int'(AWLEN));
          aw_active = 1'b1; aw_beat = 0; aw_cur_len = int'(AWLEN); aw_cur_addr = AWADDR;
        end
        if (BVALID && BREADY) b_hs = 1'b1;
        rd_en_smp = c_rd_en; rd_addr_smp = c_rd_addr;
      end
      @(posedge clk); #1;
      AWREADY = rand_mode ? ($urandom_range(0, 1) == 0) : 1'b1;
      WREADY  = rand_mode ? ($urandom_range(0, 9) < 4) : 1'b1;
      c_rd_data = rd_en_smp ? cbuf[rd_addr_smp] : 32'hDEAD_BEEF;
      if (b_hs || rst_smp) BVALID = 1'b0;
      if (b_pend && !BVALID && !rst_smp) begin
        if (b_wait == 0) begin
          burst_no++;
          BVALID = 1'b1; BRESP = (burst_no == err_burst) ? 2'b10 : 2'b00; b_pend = 1'b0;
        end else b_wait--;
      end
    end
  end

  function automatic int ddr_bad(logic [31:0] row0, logic [31:0] stride, int n, int cm);
    int bad;
    logic [31:0] a;
    bad = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < cm; c++) begin
        a = row0 + 32'(r) * stride + 32'(4 * c);
        if (!ddr.exists(a)) bad++;
        else if (ddr[a] !== cbuf[r * cm + c]) bad++;
      end
    return bad;
  endfunction

  task automatic start_op(input logic [15:0] n, m, bm, j, input logic [31:0] base, stride, input int eb);
    ddr.delete(); aw_addr_q.delete(); aw_len_q.delete(); wlast_q.delete();
    first_aw_cyc = -1; done_cyc = -1; done_cnt = 0; beats = 0; stab_err = 0; ord_err = 0;
    wlast_err = 0; busy_done_err = 0; burst_no = 0; err_burst = eb;
    @(posedge clk); #1;
    N = n; M = m; BLOCK_M = bm; j_block = j; base_c_addr = base; stride_c_row_bytes = stride;
    st_req = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    st_req = 1'b0;
  endtask

  task automatic wait_done(output bit tmo);
    tmo = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      if (done_cnt > 0) begin tmo = 1'b0; break; end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; st_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (st_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", st_busy); end
    checks++; if (st_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", st_done); end
    checks++; if (st_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", st_err); end
    checks++; if ({AWVALID, WVALID, BREADY, c_rd_en} !== 4'b0000) begin errors++; $display("FAIL reset_valids got %b exp 0000", {AWVALID, WVALID, BREADY, c_rd_en}); end
    checks++; if (AWSIZE !== 3'd2 || AWBURST !== 2'b01 || AWCACHE !== 4'b0011 || WSTRB !== 4'hF) begin errors++; $display("FAIL reset_consts got %h %h %h %h", AWSIZE, AWBURST, AWCACHE, WSTRB); end
    rst = 1'b0;
  endtask

  task automatic test_two_rows;
    bit tmo;
    start_op(16'd2, 16'd8, 16'd8, 16'd0, 32'h1000, 32'd32, 0);
    wait_done(tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL two_rows_timeout got %b exp 0", tmo); end
    checks++; if (first_aw_cyc - t0 !== 2) begin errors++; $display("FAIL two_rows_aw_cycle got %0d exp 2", first_aw_cyc - t0); end
    checks++; if (aw_addr_q.size() !== 2) begin errors++; $display("FAIL two_rows_aw_count got %0d exp 2", aw_addr_q.size()); end
    checks++; if (aw_addr_q[0] !== 32'h1000 || aw_addr_q[1] !== 32'h1020) begin errors++; $display("FAIL two_rows_awaddr got %h %h exp 1000 1020", aw_addr_q[0], aw_addr_q[1]); end
    checks++; if (aw_len_q[0] !== 7 || aw_len_q[1] !== 7) begin errors++; $display("FAIL two_rows_awlen got %0d %0d exp 7 7", aw_len_q[0], aw_len_q[1]); end
    checks++; if (wlast_q.size() !== 2 || wlast_q[0] !== 8 || wlast_q[1] !== 16) begin errors++; $display("FAIL two_rows_wlast got n=%0d %0d %0d exp 8 16", wlast_q.size(), wlast_q[0], wlast_q[1]); end
    checks++; if (ddr_bad(32'h1000, 32'd32, 2, 8) !== 0 || beats !== 16) begin errors++; $display("FAIL two_rows_data bad=%0d beats=%0d exp 0 16", ddr_bad(32'h1000, 32'd32, 2, 8), beats); end
    checks++; if (done_cnt !== 1 || busy_done_err !== 0 || st_busy !== 1'b0) begin errors++; $display("FAIL two_rows_done pulses=%0d busy_at_done=%0d busy=%b exp 1 0 0", done_cnt, busy_done_err, st_busy); end
  endtask

  task automatic test_long_row;
    bit tmo;
    start_op(16'd1, 16'd40, 16'd40, 16'd0, 32'h4000, 32'd256, 0);
    wait_done(tmo);
    checks++; if (tmo !== 1'b0 || aw_addr_q.size() !== 3) begin errors++; $display("FAIL long_row_count tmo=%b got %0d exp 3", tmo, aw_addr_q.size()); end
    checks++; if (aw_len_q[0] !== 15 || aw_len_q[1] !== 15 || aw_len_q[2] !== 7) begin errors++; $display("FAIL long_row_awlen got %0d %0d %0d exp 15 15 7", aw_len_q[0], aw_len_q[1], aw_len_q[2]); end
    checks++; if (aw_addr_q[0] !== 32'h4000 || aw_addr_q[1] !== 32'h4040 || aw_addr_q[2] !== 32'h4080) begin errors++; $display("FAIL long_row_awaddr got %h %h %h exp 4000 4040 4080", aw_addr_q[0], aw_addr_q[1], aw_addr_q[2]); end
    checks++; if (ddr_bad(32'h4000, 32'd256, 1, 40) !== 0 || beats !== 40) begin errors++; $display("FAIL long_row_data bad=%0d beats=%0d exp 0 40", ddr_bad(32'h4000, 32'd256, 1, 40), beats); end
  endtask

  task automatic test_4k_split;
    bit tmo;
    start_op(16'd1, 16'd8, 16'd8, 16'd0, 32'h1FF8, 32'd64, 0);
    wait_done(tmo);
    checks++; if (tmo !== 1'b0 || aw_addr_q.size() !== 2) begin errors++; $display("FAIL split_count tmo=%b got %0d exp 2", tmo, aw_addr_q.size()); end
    checks++; if (aw_addr_q[0] !== 32'h1FF8 || aw_len_q[0] !== 1) begin errors++; $display("FAIL split_first got %h len %0d exp 1ff8 1", aw_addr_q[0], aw_len_q[0]); end
    checks++; if (aw_addr_q[1] !== 32'h2000 || aw_len_q[1] !== 5) begin errors++; $display("FAIL split_second got %h len %0d exp 2000 5", aw_addr_q[1], aw_len_q[1]); end
    checks++; if (ddr_bad(32'h1FF8, 32'd64, 1, 8) !== 0) begin errors++; $display("FAIL split_data bad=%0d exp 0", ddr_bad(32'h1FF8, 32'd64, 1, 8)); end
  endtask

  task automatic test_edge_block;
    bit tmo;
    start_op(16'd1, 16'd100, 16'd32, 16'd96, 32'h5000, 32'd512, 0);
    wait_done(tmo);
    checks++; if (tmo !== 1'b0 || aw_addr_q.size() !== 1) begin errors++; $display("FAIL edge_count tmo=%b got %0d exp 1", tmo, aw_addr_q.size()); end
    checks++; if (aw_addr_q[0] !== 32'h5180 || aw_len_q[0] !== 3) begin errors++; $display("FAIL edge_aw got %h len %0d exp 5180 3", aw_addr_q[0], aw_len_q[0]); end
    checks++; if (ddr_bad(32'h5180, 32'd512, 1, 4) !== 0 || beats !== 4) begin errors++; $display("FAIL edge_data bad=%0d beats=%0d exp 0 4", ddr_bad(32'h5180, 32'd512, 1, 4), beats); end
    start_op(16'd1, 16'd96, 16'd32, 16'd96, 32'h5000, 32'd512, 0);
    wait_done(tmo);
    checks++; if (tmo !== 1'b0 || done_cyc - t0 !== 2) begin errors++; $display("FAIL empty_done_cycle tmo=%b got %0d exp 2", tmo, done_cyc - t0); end
    checks++; if (aw_addr_q.size() !== 0 || first_aw_cyc !== -1 || done_cnt !== 1) begin errors++; $display("FAIL empty_no_traffic aw=%0d first=%0d done=%0d exp 0 -1 1", aw_addr_q.size(), first_aw_cyc, done_cnt); end
  endtask

  task automatic test_random_stall;
    bit tmo;
    rand_mode = 1'b1;
    start_op(16'd3, 16'd40, 16'd24, 16'd8, 32'h0FA0, 32'h100, 2);
    wait_done(tmo);
    rand_mode = 1'b0;
    checks++; if (tmo !== 1'b0 || aw_addr_q.size() !== 6) begin errors++; $display("FAIL rand_count tmo=%b got %0d exp 6", tmo, aw_addr_q.size()); end
    checks++; if (aw_addr_q[1] !== 32'h1000 || aw_len_q[0] !== 15 || aw_len_q[1] !== 7) begin errors++; $display("FAIL rand_split got %h %0d %0d exp 1000 15 7", aw_addr_q[1], aw_len_q[0], aw_len_q[1]); end
    checks++; if (ddr_bad(32'h0FC0, 32'h100, 3, 24) !== 0 || beats !== 72) begin errors++; $display("FAIL rand_data bad=%0d beats=%0d exp 0 72", ddr_bad(32'h0FC0, 32'h100, 3, 24), beats); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL rand_stable got %0d exp 0", stab_err); end
    checks++; if (ord_err !== 0 || wlast_err !== 0) begin errors++; $display("FAIL rand_order ord=%0d wlast=%0d exp 0 0", ord_err, wlast_err); end
    checks++; if (st_err !== 1'b1 || done_cnt !== 1) begin errors++; $display("FAIL rand_err got %b done=%0d exp 1 1", st_err, done_cnt); end
    start_op(16'd1, 16'd4, 16'd4, 16'd0, 32'h7000, 32'd16, 0);
    checks++; if (st_err !== 1'b0 || st_busy !== 1'b1) begin errors++; $display("FAIL err_clear got err=%b busy=%b exp 0 1", st_err, st_busy); end
    wait_done(tmo);
    checks++; if (tmo !== 1'b0 || st_err !== 1'b0 || ddr_bad(32'h7000, 32'd16, 1, 4) !== 0) begin errors++; $display("FAIL err_clear_op tmo=%b err=%b bad=%0d", tmo, st_err, ddr_bad(32'h7000, 32'd16, 1, 4)); end
  endtask

  task automatic test_reset_mid;
    bit tmo;
    bit seen;
    seen = 1'b0;
    start_op(16'd2, 16'd16, 16'd16, 16'd0, 32'h3000, 32'd64, 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (WVALID) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_reach_w got %b exp 1", seen); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({AWVALID, WVALID, WLAST, BREADY, c_rd_en, st_busy, st_done, st_err} !== 8'h00) begin errors++; $display("FAIL mid_reset_outputs got %b exp 0", {AWVALID, WVALID, WLAST, BREADY, c_rd_en, st_busy, st_done, st_err}); end
    checks++; if (AWADDR !== 32'd0 || c_rd_addr !== 14'd0) begin errors++; $display("FAIL mid_reset_addr got %h %h exp 0 0", AWADDR, c_rd_addr); end
    rst = 1'b0;
    start_op(16'd1, 16'd8, 16'd8, 16'd0, 32'h6000, 32'd32, 0);
    wait_done(tmo);
    checks++; if (tmo !== 1'b0 || done_cnt !== 1 || beats !== 8 || ddr_bad(32'h6000, 32'd32, 1, 8) !== 0) begin errors++; $display("FAIL mid_after_op tmo=%b done=%0d beats=%0d bad=%0d", tmo, done_cnt, beats, ddr_bad(32'h6000, 32'd32, 1, 8)); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) cbuf[i] = 32'hC0DE_0000 + 32'(i);
    N = 16'd0; M = 16'd0; BLOCK_M = 16'd0; j_block = 16'd0;
    base_c_addr = 32'd0; stride_c_row_bytes = 32'd0; st_req = 1'b0; rst = 1'b1;
    first_aw_cyc = -1; done_cyc = -1; done_cnt = 0; beats = 0; stab_err = 0; ord_err = 0;
    wlast_err = 0; busy_done_err = 0; burst_no = 0; err_burst = 0; t0 = 0;
    test_reset();
    test_two_rows();
    test_long_row();
    test_4k_split();
    test_edge_block();
    test_random_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
